// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte master among NUM_REQ requesters, with burst lock.
// Define SPI_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles without m_done.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_err,
  output logic                       m_start,
  output logic [7:0]                 m_tx_data,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic [7:0]                 m_rx_data,
  output logic [$clog2(NUM_REQ)-1:0] cur_owner,
  output logic                       arb_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [NUM_REQ-1:0] req_ready_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [7:0]         rsp_data_reg;
  logic               rsp_err_reg;
  logic               m_start_reg;
  logic [7:0]         tx_data_reg;

  logic [7:0]         req_byte [NUM_REQ];
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               lock_ok;
  logic [IDX_W-1:0]   next_ptr;
  logic               tmo_hit;

  // cand_idx[k] is the k-th requester visited when searching from rr_ptr
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_byte[gi] = req_data[8*gi +: 8];
    assign cand_idx[gi] = IDX_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[cand_idx[i]]) begin
        found  = 1'b1;
        winner = cand_idx[i];
      end
    end
  end

  // A timed-out transfer never keeps its burst lock
  assign lock_ok  = req_lock[owner_reg] && req_valid[owner_reg] && !rsp_err_reg;
  assign next_ptr = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_reg;

  assign tmo_hit = (state_reg == WAIT) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == WAIT && !m_done && !tmo_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
    end else begin
      tmo_cnt_reg <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= 8'h00;
      rsp_err_reg   <= 1'b0;
      m_start_reg   <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      m_start_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found && !m_busy) begin
            req_ready_reg <= NUM_REQ'(1) << winner;
            owner_reg     <= winner;
            tx_data_reg   <= req_byte[winner];
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          m_start_reg <= 1'b1;
          state_reg   <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            rsp_data_reg  <= m_rx_data;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
            state_reg     <= RESP;
          end else if (tmo_hit) begin
            rsp_data_reg  <= 8'h00;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (lock_ok) begin
            req_ready_reg <= NUM_REQ'(1) << owner_reg;
            tx_data_reg   <= req_byte[owner_reg];
            state_reg     <= ISSUE;
          end else begin
            rr_ptr_reg  <= next_ptr;
            tx_data_reg <= 8'h00;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign m_start   = m_start_reg;
  assign m_tx_data = tx_data_reg;
  assign cur_owner = owner_reg;
  assign arb_busy  = (state_reg != IDLE);

endmodule
